sync_fifo: RTL and testbench

Single-clock, parametrised first-word-fall-through (FWFT) FIFO with valid/ready handshakes on both sides. It is the same-clock counterpart of the dual-clock FIFO and is used wherever producer and consumer share a clock. Unlike the dual-clock FIFO, it supports any depth (power of 2 not required), provides registered read data with zero-bubble streaming, and can optionally report its fill level and almost-full/almost-empty thresholds.

---
 rtl/sync_fifo.sv | 139 +++++++++++++
 tb/tb_sync_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO, valid/ready on both
// sides, any depth >= 2. The RAM's registered read port is the output
// register, so a write in cycle N is visible in cycle N+2 with no bypass.
// Optional status outputs (level, almost_full, almost_empty) are built only
// when SYNC_FIFO_STATUS_EN is defined.
module sync_fifo #(
  parameter int P_DEPTH     = 1024,
  parameter int P_WIDTH     = 8,
  parameter int P_AF_THRESH = P_DEPTH - 2,
  parameter int P_AE_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [P_WIDTH-1:0] wr_data,
  input  logic               wr_vld,
  output logic               wr_rdy,
  output logic [P_WIDTH-1:0] rd_data,
  output logic               rd_vld,
  input  logic               rd_rdy
`ifdef SYNC_FIFO_STATUS_EN
  ,
  output logic [$clog2(P_DEPTH+1)-1:0] level,
  output logic                         almost_full,
  output logic                         almost_empty
`endif
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int OW = $clog2(P_DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(P_DEPTH - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(P_DEPTH);

  // Parameter sanity: thresholds must lie inside the reachable level range.
  if (P_DEPTH < 2 || P_AF_THRESH < 0 || P_AF_THRESH > P_DEPTH ||
      P_AE_THRESH < 0 || P_AE_THRESH > P_DEPTH) begin : g_bad_param
    $error("sync_fifo: illegal depth or threshold parameter");
  end

  typedef enum logic [1:0] {EMPTY, FETCH, VALID} state_e;

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic               wr_rdy_q;
  logic [P_WIDTH-1:0] rd_data_q;
  state_e             state_q, state_d;
  logic               wr_en, pop, mem_has, rd_issue;

  assign wr_en    = wr_vld & wr_rdy_q;
  assign pop      = rd_vld & rd_rdy;
  // Words still in memory = occ minus the one sitting in the output register.
  assign mem_has  = occ_q > {{(OW-1){1'b0}}, rd_vld};
  // Prefetch whenever memory has a word and the output slot frees up.
  assign rd_issue = mem_has & (~rd_vld | rd_rdy);

  assign wr_rdy  = wr_rdy_q;
  assign rd_data = rd_data_q;
  assign rd_vld  = (state_q != EMPTY);

  // Pointer wrap and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en)    wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    if (rd_issue) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Prefetch FSM: FETCH = word just landed, VALID = word being held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:        if (rd_issue) state_d = FETCH;
      FETCH, VALID: if (rd_issue)  state_d = FETCH;
                    else if (pop)  state_d = EMPTY;
                    else           state_d = VALID;
      default:      state_d = EMPTY;
    endcase
  end

  // Control registers; wr_rdy is registered from occ_d so it never sees rd_rdy combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      wr_rdy_q <= 1'b0;
      state_q  <= EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      wr_rdy_q <= (occ_d < OCC_FULL);
      state_q  <= state_d;
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  // RAM registered read port doubles as the output register.
  always_ff @(posedge clk) begin
    if (rst)           rd_data_q <= '0;
    else if (rd_issue) rd_data_q <= mem[rd_ptr_q];
  end

`ifdef SYNC_FIFO_STATUS_EN
  localparam logic [OW-1:0] AF_C = OW'(P_AF_THRESH);
  localparam logic [OW-1:0] AE_C = OW'(P_AE_THRESH);

  logic [OW-1:0] level_q;
  logic          af_q, ae_q;

  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

  // Status flags track occupancy after this cycle's events.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      level_q <= occ_d;
      af_q    <= (occ_d >= AF_C);
      ae_q    <= (occ_d <= AE_C);
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo (depth 5, width 8).
// Status ports are checked only when SYNC_FIFO_STATUS_EN is defined.
module tb_sync_fifo;
  localparam int DEPTH = 5;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    wr_data;
  logic          wr_vld, wr_rdy;
  logic [7:0]    rd_data;
  logic          rd_vld, rd_rdy;
`ifdef SYNC_FIFO_STATUS_EN
  logic [LW-1:0] level;
  logic          almost_full, almost_empty;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb[$];

  sync_fifo #(.P_DEPTH(DEPTH), .P_WIDTH(8), .P_AF_THRESH(DEPTH-2), .P_AE_THRESH(2)) dut (
    .clk(clk), .rst(rst),
    .wr_data(wr_data), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_rdy(rd_rdy)
`ifdef SYNC_FIFO_STATUS_EN
    , .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // One clock cycle: drive inputs, account handshakes against the scoreboard,
  // advance to 1 time unit after the next rising edge.
  task automatic cyc(input logic wv, input logic [7:0] wd, input logic rr,
                     output logic popped, output logic [7:0] got,
                     output logic [7:0] exp, output logic wrote);
    wr_vld = wv; wr_data = wd; rd_rdy = rr;
    wrote  = wv & wr_rdy;
    popped = rd_vld & rr;
    got    = rd_data;
    exp    = rd_data;
    if (popped) begin
      if (sb.size() == 0) exp = rd_data ^ 8'hFF;
      else                exp = sb.pop_front();
    end
    if (wrote) sb.push_back(wd);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_vld = 1'b0; rd_rdy = 1'b0; wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rd_vld !== 1'b0)   begin n_bad++; $display("FAIL reset_rd_vld got %b want 0", rd_vld); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    n_cmp++; if (wr_rdy !== 1'b0)   begin n_bad++; $display("FAIL reset_wr_rdy got %b want 0", wr_rdy); end
`ifdef SYNC_FIFO_STATUS_EN
    n_cmp++; if (level !== '0)      begin n_bad++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (almost_full !== 1'b0)  begin n_bad++; $display("FAIL reset_af got %b want 0", almost_full); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_ae got %b want 1", almost_empty); end
`endif
    rst = 1'b0;
    n_cmp++; if (wr_rdy !== 1'b0) begin n_bad++; $display("FAIL post_reset_wr_rdy got %b want 0", wr_rdy); end
    @(posedge clk); #1;
    n_cmp++; if (wr_rdy !== 1'b1) begin n_bad++; $display("FAIL wr_rdy_rise got %b want 1", wr_rdy); end
  endtask

  task automatic test_first_write();
    logic p, w; logic [7:0] g, e;
    cyc(1'b1, 8'hA1, 1'b0, p, g, e, w);
    n_cmp++; if (w !== 1'b1)      begin n_bad++; $display("FAIL first_write_accept got %b want 1", w); end
    n_cmp++; if (rd_vld !== 1'b0) begin n_bad++; $display("FAIL first_write_n1_vld got %b want 0", rd_vld); end
    cyc(1'b0, 8'h00, 1'b0, p, g, e, w);
    n_cmp++; if (rd_vld !== 1'b1 || rd_data !== 8'hA1)
      begin n_bad++; $display("FAIL first_write_n2 got vld=%b data=%h want vld=1 data=a1", rd_vld, rd_data); end
`ifdef SYNC_FIFO_STATUS_EN
    n_cmp++; if (level !== LW'(1)) begin n_bad++; $display("FAIL first_write_level got %0d want 1", level); end
`endif
    cyc(1'b0, 8'h00, 1'b1, p, g, e, w);
    n_cmp++; if (p !== 1'b1 || g !== e) begin n_bad++; $display("FAIL first_write_pop got p=%b %h want p=1 %h", p, g, e); end
  endtask

  task automatic test_fill();
    logic p, w; logic [7:0] g, e;
    int acc = 0;
    for (int v = 1; v <= 7; v++) begin
      cyc(1'b1, 8'(v), 1'b0, p, g, e, w);
      if (w) acc++;
      n_cmp++; if (wr_rdy !== (acc < DEPTH))
        begin n_bad++; $display("FAIL fill_wr_rdy step %0d got %b want %b", v, wr_rdy, acc < DEPTH); end
`ifdef SYNC_FIFO_STATUS_EN
      n_cmp++; if (level !== LW'(acc) || almost_full !== (acc >= 3) || almost_empty !== (acc <= 2))
        begin n_bad++; $display("FAIL fill_status step %0d got lvl=%0d af=%b ae=%b want lvl=%0d af=%b ae=%b",
                                v, level, almost_full, almost_empty, acc, acc >= 3, acc <= 2); end
`endif
    end
    n_cmp++; if (acc != DEPTH) begin n_bad++; $display("FAIL fill_accepted got %0d want %0d", acc, DEPTH); end
    n_cmp++; if (rd_vld !== 1'b1 || rd_data !== 8'h01)
      begin n_bad++; $display("FAIL fill_head got vld=%b %h want vld=1 01", rd_vld, rd_data); end
  endtask

  task automatic test_pop_full_wrap();
    logic p, w; logic [7:0] g, e;
    logic [7:0] order[5];
    int np = 0;
    order = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    cyc(1'b0, 8'h00, 1'b1, p, g, e, w);
    n_cmp++; if (p !== 1'b1 || g !== 8'h01) begin n_bad++; $display("FAIL full_pop got p=%b %h want p=1 01", p, g); end
    n_cmp++; if (wr_rdy !== 1'b1) begin n_bad++; $display("FAIL full_pop_wr_rdy got %b want 1", wr_rdy); end
    cyc(1'b1, 8'h06, 1'b0, p, g, e, w);
    n_cmp++; if (w !== 1'b1) begin n_bad++; $display("FAIL wrap_write got %b want 1", w); end
    for (int c = 0; c < 20 && np < 5; c++) begin
      cyc(1'b0, 8'h00, 1'b1, p, g, e, w);
      if (p) begin
        n_cmp++; if (g !== order[np] || g !== e)
          begin n_bad++; $display("FAIL wrap_order idx %0d got %h want %h", np, g, order[np]); end
        np++;
      end
    end
    n_cmp++; if (np != 5) begin n_bad++; $display("FAIL wrap_drain_count got %0d want 5", np); end
  endtask

  task automatic test_occ1_simul();
    logic p, w; logic [7:0] g, e;
    cyc(1'b1, 8'h33, 1'b0, p, g, e, w);
    cyc(1'b0, 8'h00, 1'b0, p, g, e, w);
    cyc(1'b1, 8'h44, 1'b1, p, g, e, w);
    n_cmp++; if (p !== 1'b1 || g !== 8'h33 || w !== 1'b1)
      begin n_bad++; $display("FAIL occ1_xfer got p=%b w=%b %h want 1 1 33", p, w, g); end
    n_cmp++; if (rd_vld !== 1'b0) begin n_bad++; $display("FAIL occ1_bubble got %b want 0", rd_vld); end
    cyc(1'b0, 8'h00, 1'b0, p, g, e, w);
    n_cmp++; if (rd_vld !== 1'b1 || rd_data !== 8'h44)
      begin n_bad++; $display("FAIL occ1_head got vld=%b %h want 1 44", rd_vld, rd_data); end
    cyc(1'b0, 8'h00, 1'b1, p, g, e, w);
    n_cmp++; if (p !== 1'b1 || g !== e) begin n_bad++; $display("FAIL occ1_pop got %h want %h", g, e); end
  endtask

  task automatic test_stream();
    logic p, w; logic [7:0] g, e;
    int run = 0, max_run = 0, npop = 0, bad_data = 0, bad_lvl = 0;
    for (int i = 0; i < 262; i++) begin
`ifdef SYNC_FIFO_STATUS_EN
      if (level > LW'(2)) bad_lvl++;
`endif
      cyc(i < 256, 8'(i), 1'b1, p, g, e, w);
      if (p) begin
        npop++; run++;
        if (run > max_run) max_run = run;
        if (g !== e) bad_data++;
      end else run = 0;
    end
    n_cmp++; if (npop != 256)    begin n_bad++; $display("FAIL stream_count got %0d want 256", npop); end
    n_cmp++; if (max_run != 256) begin n_bad++; $display("FAIL stream_no_bubble got run %0d want 256", max_run); end
    n_cmp++; if (bad_data != 0)  begin n_bad++; $display("FAIL stream_order got %0d bad words want 0", bad_data); end
    n_cmp++; if (bad_lvl != 0)   begin n_bad++; $display("FAIL stream_level got %0d cycles above 2 want 0", bad_lvl); end
  endtask

  task automatic test_backpressure();
    logic p, w; logic [7:0] g, e;
    logic pv, prr, a, b; logic [7:0] pd;
    int acc = 0, hold_bad = 0, comb_bad = 0, data_bad = 0;
    for (int c = 0; c < 10000 && acc < 1000; c++) begin
      rd_rdy = 1'b0; #1; a = wr_rdy;
      rd_rdy = 1'b1; #1; b = wr_rdy;
      if (a !== b) comb_bad++;
      pv = rd_vld; pd = rd_data; prr = 1'(($urandom % 2));
      cyc(1'(($urandom % 4) != 0), 8'($urandom), prr, p, g, e, w);
      if (w) acc++;
      if (p && g !== e) data_bad++;
      if (pv && !prr && (rd_vld !== 1'b1 || rd_data !== pd)) hold_bad++;
    end
    for (int c = 0; c < 50 && (sb.size() != 0 || rd_vld); c++) begin
      cyc(1'b0, 8'h00, 1'b1, p, g, e, w);
      if (p && g !== e) data_bad++;
    end
    n_cmp++; if (acc != 1000)     begin n_bad++; $display("FAIL bp_accepted got %0d want 1000", acc); end
    n_cmp++; if (data_bad != 0)   begin n_bad++; $display("FAIL bp_data got %0d bad words want 0", data_bad); end
    n_cmp++; if (hold_bad != 0)   begin n_bad++; $display("FAIL bp_hold got %0d unstable cycles want 0", hold_bad); end
    n_cmp++; if (comb_bad != 0)   begin n_bad++; $display("FAIL bp_comb_wr_rdy got %0d want 0", comb_bad); end
    n_cmp++; if (sb.size() != 0 || rd_vld !== 1'b0)
      begin n_bad++; $display("FAIL bp_drained got left=%0d vld=%b want 0 0", sb.size(), rd_vld); end
  endtask

  task automatic test_reset_mid();
    logic p, w; logic [7:0] g, e;
    for (int v = 0; v < 4; v++) cyc(1'b1, 8'(8'h90 + v), 1'b0, p, g, e, w);
`ifdef SYNC_FIFO_STATUS_EN
    n_cmp++; if (level !== LW'(4)) begin n_bad++; $display("FAIL mid_pre_level got %0d want 4", level); end
`endif
    rst = 1'b1; wr_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    n_cmp++; if (rd_vld !== 1'b0 || rd_data !== 8'h00)
      begin n_bad++; $display("FAIL mid_rst_out got vld=%b %h want 0 00", rd_vld, rd_data); end
`ifdef SYNC_FIFO_STATUS_EN
    n_cmp++; if (level !== '0 || almost_empty !== 1'b1)
      begin n_bad++; $display("FAIL mid_rst_status got lvl=%0d ae=%b want 0 1", level, almost_empty); end
`endif
    cyc(1'b0, 8'h00, 1'b0, p, g, e, w);
    cyc(1'b1, 8'h5C, 1'b0, p, g, e, w);
    n_cmp++; if (w !== 1'b1) begin n_bad++; $display("FAIL mid_write got %b want 1", w); end
    cyc(1'b0, 8'h00, 1'b0, p, g, e, w);
    cyc(1'b0, 8'h00, 1'b1, p, g, e, w);
    n_cmp++; if (p !== 1'b1 || g !== 8'h5C || g !== e)
      begin n_bad++; $display("FAIL mid_readback got p=%b %h want 1 5c", p, g); end
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_fill();
    test_pop_full_wrap();
    test_occ1_simul();
    test_stream();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
